// File: rtl/half_duplex_pin_ctrl_pkg.sv
// Shared types and constants for the half-duplex pin sequencer.
package half_duplex_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        TURN   = 2'd2,
        SAMPLE = 2'd3
    } state_t;

    localparam logic DIR_READ  = 1'b0;
    localparam logic DIR_WRITE = 1'b1;

    localparam int unsigned BITS_PER_XFER = 8;

endpackage

// File: rtl/half_duplex_pin_ctrl_pin_sync.sv
// Two-flop synchronizer bringing the asynchronous pin level into the clk48 domain.
module pin_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/half_duplex_pin_ctrl.sv
// Half-duplex tristate pin sequencer: serialises a byte out or samples a byte in,
// always separating local and remote drive with a hi-Z turnaround guard.
module half_duplex_pin_ctrl
    import half_duplex_pkg::*;
#(
    parameter int unsigned BIT_CYCLES  = 48,
    parameter int unsigned TURN_CYCLES = 4
) (
    input  logic       clk48,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_dir,
    input  logic [7:0] cmd_data,
    output logic       done,
    output logic [7:0] rsp_data,
    output logic       pin_o,
    output logic       pin_t,
    input  logic       pin_i
);

    localparam int unsigned CW = $clog2(BIT_CYCLES);
    localparam int unsigned TW = $clog2(TURN_CYCLES + 1);

    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] BIT_MID   = CW'(BIT_CYCLES / 2);
    localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYCLES - 1);
    localparam logic [2:0]    IDX_LAST  = 3'(BITS_PER_XFER - 1);

    state_t                   state, state_n;
    logic [CW-1:0]            bit_cnt, bit_cnt_n;
    logic [2:0]               bit_idx, bit_idx_n;
    logic [TW-1:0]            turn_cnt, turn_cnt_n;
    logic [BITS_PER_XFER-1:0] tx_sr, tx_n;
    logic [BITS_PER_XFER-1:0] rx_sr, rx_n;
    logic                     dir_q, dir_n;
    logic                     pin_o_n, pin_t_n;
    logic                     ready_n, done_n;
    logic [7:0]               rsp_n;
    logic                     pin_s;

    pin_sync u_pin_sync (
        .clk   (clk48),
        .rst_n (rst_n),
        .d     (pin_i),
        .q     (pin_s)
    );

    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            turn_cnt  <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            dir_q     <= DIR_READ;
            pin_o     <= 1'b0;
            pin_t     <= 1'b1;
            cmd_ready <= 1'b0;
            done      <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            bit_idx   <= bit_idx_n;
            turn_cnt  <= turn_cnt_n;
            tx_sr     <= tx_n;
            rx_sr     <= rx_n;
            dir_q     <= dir_n;
            pin_o     <= pin_o_n;
            pin_t     <= pin_t_n;
            cmd_ready <= ready_n;
            done      <= done_n;
            rsp_data  <= rsp_n;
        end
    end

    // Outputs are computed from the next state so that they are registered yet
    // line up with the state they belong to.
    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        bit_idx_n  = bit_idx;
        turn_cnt_n = turn_cnt;
        tx_n       = tx_sr;
        rx_n       = rx_sr;
        dir_n      = dir_q;
        pin_o_n    = pin_o;
        pin_t_n    = pin_t;
        rsp_n      = rsp_data;
        done_n     = 1'b0;

        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    dir_n      = cmd_dir;
                    bit_cnt_n  = '0;
                    bit_idx_n  = '0;
                    turn_cnt_n = '0;
                    if (cmd_dir == DIR_WRITE) begin
                        state_n = DRIVE;
                        tx_n    = cmd_data;
                        pin_o_n = cmd_data[BITS_PER_XFER-1];
                        pin_t_n = 1'b0;
                    end else begin
                        state_n = TURN;
                        pin_o_n = 1'b0;
                        pin_t_n = 1'b1;
                    end
                end
            end

            DRIVE: begin
                if (bit_cnt == BIT_LAST) begin
                    bit_cnt_n = '0;
                    if (bit_idx == IDX_LAST) begin
                        state_n    = TURN;
                        turn_cnt_n = '0;
                        pin_o_n    = 1'b0;
                        pin_t_n    = 1'b1;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        tx_n      = {tx_sr[BITS_PER_XFER-2:0], 1'b0};
                        pin_o_n   = tx_sr[BITS_PER_XFER-2];
                    end
                end else begin
                    bit_cnt_n = bit_cnt + CW'(1);
                end
            end

            // Writes leave through the guard; reads enter the sample window through it.
            TURN: begin
                if (turn_cnt == TURN_LAST) begin
                    turn_cnt_n = '0;
                    if (dir_q == DIR_WRITE) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        state_n   = SAMPLE;
                        bit_cnt_n = '0;
                        bit_idx_n = '0;
                    end
                end else begin
                    turn_cnt_n = turn_cnt + TW'(1);
                end
            end

            SAMPLE: begin
                if (bit_cnt == BIT_MID) begin
                    rx_n = {rx_sr[BITS_PER_XFER-2:0], pin_s};
                end
                if (bit_cnt == BIT_LAST) begin
                    bit_cnt_n = '0;
                    if (bit_idx == IDX_LAST) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                        rsp_n   = rx_n;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    bit_cnt_n = bit_cnt + CW'(1);
                end
            end

            default: begin
                state_n = IDLE;
                pin_o_n = 1'b0;
                pin_t_n = 1'b1;
            end
        endcase

        ready_n = (state_n == IDLE);
    end

endmodule

// File: tb/tb_half_duplex_pin_ctrl.sv
// Scoreboard bench: every command pushes its per-cycle expected pin/handshake trace,
// which is popped and compared cycle by cycle on the falling clock edge.
module tb_half_duplex_pin_ctrl;

    localparam int unsigned BC   = 8;
    localparam int unsigned TC   = 2;
    localparam int unsigned XFER = 8 * BC + TC + 1;

    logic       clk48 = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_dir;
    logic [7:0] cmd_data;
    logic       done;
    logic [7:0] rsp_data;
    logic       pin_o;
    logic       pin_t;
    logic       pin_i;

    typedef struct {
        int unsigned cyc;
        logic        t;
        logic        o;
        logic        rdy;
        logic        dn;
        logic [7:0]  rsp;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    int unsigned ready_from = 0;
    int unsigned cur_a = 0;
    int unsigned rd_a = 0;
    logic [7:0]  rd_byte = 8'h00;
    logic [7:0]  last_rsp = 8'h00;
    bit          rd_on = 1'b0;
    bit          tog_on = 1'b0;

    half_duplex_pin_ctrl #(
        .BIT_CYCLES  (BC),
        .TURN_CYCLES (TC)
    ) dut (
        .clk48     (clk48),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dir   (cmd_dir),
        .cmd_data  (cmd_data),
        .done      (done),
        .rsp_data  (rsp_data),
        .pin_o     (pin_o),
        .pin_t     (pin_t),
        .pin_i     (pin_i)
    );

    always #5 clk48 = ~clk48;

    always @(posedge clk48) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // One falling edge: compare this cycle's expectation, then drive the remote pin.
    task automatic tick();
        exp_t e;
        int unsigned k;
        @(negedge clk48);
        while (sb.size() > 0 && sb[0].cyc < cyc) void'(sb.pop_front());
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            check("pin_t", pin_t, e.t);
            check("pin_o", pin_o, e.o);
            check("cmd_ready", cmd_ready, e.rdy);
            check("done", done, e.dn);
            if (e.dn) check("rsp_data", rsp_data, e.rsp);
        end else begin
            check("idle_done", done, 1'b0);
        end
        if (tog_on) begin
            pin_i = cyc[0];
        end else if (rd_on && cyc >= rd_a + TC && cyc < rd_a + TC + 8 * BC) begin
            k = (cyc - rd_a - TC) / BC;
            pin_i = rd_byte[7 - k];
        end else begin
            pin_i = 1'b0;
        end
    endtask

    task automatic wait_until(input int unsigned target);
        while (cyc < target) tick();
    endtask

    // Offer a command now; predict its accept edge and push its whole trace.
    task automatic drive_cmd(input logic dir, input logic [7:0] data,
                             input logic [7:0] remote, input bit toggle);
        int unsigned a;
        exp_t e;
        cmd_valid = 1'b1;
        cmd_dir   = dir;
        cmd_data  = data;
        a = (cyc >= ready_from) ? cyc + 1 : ready_from + 1;
        if (dir == 1'b0) begin
            last_rsp = toggle ? (a[0] ? 8'hFF : 8'h00) : remote;
            rd_a     = a;
            rd_byte  = remote;
            rd_on    = !toggle;
        end
        for (int unsigned j = 0; j < XFER; j++) begin
            e.cyc = a + j;
            e.t   = !(dir && j < 8 * BC);
            e.o   = (dir && j < 8 * BC) ? data[7 - j / BC] : 1'b0;
            e.rdy = (j == XFER - 1);
            e.dn  = (j == XFER - 1);
            e.rsp = last_rsp;
            sb.push_back(e);
        end
        ready_from = a + XFER - 1;
        cur_a      = a;
    endtask

    task automatic reset_pulse(input int unsigned low_cycles);
        rst_n = 1'b0;
        sb.delete();
        last_rsp   = 8'h00;
        ready_from = 32'hFFFF_0000;
        cmd_valid  = 1'b0;
        #1;
        check("rst_pin_t", pin_t, 1'b1);
        check("rst_pin_o", pin_o, 1'b0);
        check("rst_ready", cmd_ready, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_rsp", rsp_data, 8'h00);
        repeat (low_cycles) tick();
        rst_n = 1'b1;
        ready_from = cyc + 1;
        check("ready_pre_edge", cmd_ready, 1'b0);
        tick();
        check("ready_post_edge", cmd_ready, 1'b1);
        check("pin_t_post_rst", pin_t, 1'b1);
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_dir   = 1'b0;
        cmd_data  = 8'h00;
        pin_i     = 1'b0;
        tick();
        reset_pulse(2);

        // 1: write 0xA5
        drive_cmd(1'b1, 8'hA5, 8'h00, 1'b0);
        wait_until(cur_a);
        cmd_valid = 1'b0;
        wait_until(cur_a + XFER + 2);

        // 2: read, remote drives 0x3C
        drive_cmd(1'b0, 8'h00, 8'h3C, 1'b0);
        wait_until(cur_a);
        cmd_valid = 1'b0;
        wait_until(cur_a + XFER + 2);

        // 3: write 0xFF then read accepted in the write's done cycle
        drive_cmd(1'b1, 8'hFF, 8'h00, 1'b0);
        wait_until(cur_a);
        cmd_valid = 1'b0;
        wait_until(cur_a + XFER - 1);
        drive_cmd(1'b0, 8'h00, 8'h96, 1'b0);
        wait_until(cur_a);
        cmd_valid = 1'b0;
        wait_until(cur_a + XFER + 2);

        // 4: cmd_valid held through a write with new data offered
        drive_cmd(1'b1, 8'h5A, 8'h00, 1'b0);
        wait_until(cur_a);
        drive_cmd(1'b1, 8'hC3, 8'h00, 1'b0);
        wait_until(cur_a);
        cmd_valid = 1'b0;
        wait_until(cur_a + XFER + 2);

        // 5: reset mid-write
        drive_cmd(1'b1, 8'h0F, 8'h00, 1'b0);
        wait_until(cur_a);
        cmd_valid = 1'b0;
        wait_until(cur_a + 19);
        reset_pulse(3);
        repeat (XFER) tick();

        // 6: read with pin_i toggling every cycle
        tog_on = 1'b1;
        drive_cmd(1'b0, 8'h00, 8'h00, 1'b1);
        wait_until(cur_a);
        cmd_valid = 1'b0;
        wait_until(cur_a + XFER + 2);
        tog_on = 1'b0;

        // rsp_data must persist across a following write
        drive_cmd(1'b1, 8'h81, 8'h00, 1'b0);
        wait_until(cur_a);
        cmd_valid = 1'b0;
        wait_until(cur_a + XFER + 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
